// File: rtl/adder_result_accumulator.sv
// rtl/adder_result_accumulator.sv - sums COUNT adder results ({Cout,S}) per frame, valid/ready in and out
// Optional: ACC_SATURATE_EN clamps the frame sum at 2^ACC_W-1 on overflow instead of wrapping.
module adder_result_accumulator #(
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       S,
  input  logic             Cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic [7:0]       frame_cnt
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_run;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [7:0]       r_cnt;
  logic             w_accept;
  logic             w_release;
  logic [ACC_W:0]   w_v;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_next;

  // r_run keeps in_ready low until the first edge after reset release
  assign in_ready  = r_run && (r_state == ACCUM);
  assign out_valid = (r_state == HOLD);
  assign w_accept  = in_valid && in_ready && !clear;
  assign w_release = out_valid && out_ready;

  assign w_v   = {{(ACC_W-4){1'b0}}, Cout, S};
  assign w_sum = {1'b0, r_acc} + w_v;

`ifdef ACC_SATURATE_EN
  assign w_acc_next = (w_sum[ACC_W] || r_ovf) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = ACCUM;
    end else begin
      case (r_state)
        ACCUM:   if (w_accept && (r_cnt == LAST_CNT)) w_next_state = HOLD;
        HOLD:    if (out_ready) w_next_state = ACCUM;
        default: w_next_state = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_run   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (clear || w_release) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_acc_next;
      r_ovf <= r_ovf | w_sum[ACC_W];
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign acc_out   = r_acc;
  assign overflow  = r_ovf;
  assign frame_cnt = r_cnt;

endmodule
